// File: rtl/keccak_share_compress_pkg.sv
// Shared Keccak masking helpers: share-count and share-index arithmetic
// used by the chi S-box and the share compression stage.
package keccak_share_compress_pkg;

  localparam int NUM_LANES = 5;

  function automatic int share_width(input int d);
    return (d + 1) * (d + 1);
  endfunction

  // Expanded share j of compressed share i sits at bit i*(d+1)+j.
  function automatic int share_idx(input int d, input int i, input int j);
    return i * (d + 1) + j;
  endfunction

endpackage

// File: rtl/keccak_share_row_xor.sv
// Combinational XOR of one row of expanded shares into a single share.
// Zero latency, no state, no backpressure.
module keccak_share_row_xor #(
  parameter int N = 4
) (
  input  logic [N-1:0] shares,
  output logic         y
);

  assign y = ^shares;

endmodule

// File: rtl/keccak_share_compress.sv
// Two-stage pipeline folding (d+1)^2 expanded shares per chi-row bit into d+1 shares.
// Latency 2 cycles, one transfer per cycle; valid/ready stall holds the output stage.
module keccak_share_compress
  import keccak_share_compress_pkg::*;
#(
  parameter int d = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [share_width(d)-1:0] ap_in,
  input  logic [share_width(d)-1:0] bp_in,
  input  logic [share_width(d)-1:0] cp_in,
  input  logic [share_width(d)-1:0] dp_in,
  input  logic [share_width(d)-1:0] ep_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [d:0]                a_out,
  output logic [d:0]                b_out,
  output logic [d:0]                c_out,
  output logic [d:0]                d_out,
  output logic [d:0]                e_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                occupancy
);

  localparam int SW = share_width(d);
  localparam int NS = d + 1;

  logic [NUM_LANES-1:0][SW-1:0] in_sh;
  logic [NUM_LANES-1:0][SW-1:0] e_sh;
  logic [NUM_LANES-1:0][NS-1:0] c_sh;
  logic [NUM_LANES*NS-1:0]      comp;
  logic                         e_vld;
  logic                         c_vld;
  logic                         e_adv;
  logic                         c_adv;

  assign in_sh = {ep_in, dp_in, cp_in, bp_in, ap_in};

  // Compression reads only the stage E registers so input glitches never reach the XOR tree.
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    for (genvar i = 0; i < NS; i++) begin : g_share
      keccak_share_row_xor #(.N(NS)) u_row_xor (
        .shares (e_sh[b][share_idx(d, i, 0) +: NS]),
        .y      (comp[b*NS + i])
      );
    end
  end

  assign c_adv    = !c_vld || out_ready;
  assign e_adv    = !e_vld || c_adv;
  assign in_ready = e_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld <= 1'b0;
      e_sh  <= '0;
    end else if (flush) begin
      e_vld <= 1'b0;
      e_sh  <= '0;
    end else if (e_adv) begin
      e_vld <= in_valid;
      e_sh  <= in_valid ? in_sh : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld <= 1'b0;
      c_sh  <= '0;
    end else if (flush) begin
      c_vld <= 1'b0;
      c_sh  <= '0;
    end else if (c_adv) begin
      c_vld <= e_vld;
      c_sh  <= e_vld ? comp : '0;
    end
  end

  assign out_valid = c_vld;
  assign a_out     = c_sh[0];
  assign b_out     = c_sh[1];
  assign c_out     = c_sh[2];
  assign d_out     = c_sh[3];
  assign e_out     = c_sh[4];
  assign occupancy = {1'b0, e_vld} + {1'b0, c_vld};

endmodule

// File: tb/tb_keccak_share_compress.sv
// Self-checking bench: directed d=1 scenarios plus randomized d=3 traffic against a queue model.
module tb_keccak_share_compress;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;

  logic [3:0]  in1 [5];
  logic [1:0]  out1 [5];
  logic        iv1, ir1, ov1, or1;
  logic [1:0]  occ1;

  logic [15:0] in3 [5];
  logic [3:0]  out3 [5];
  logic        iv3, ir3, ov3, or3;
  logic [1:0]  occ3;

  int checks   = 0;
  int failures = 0;

  typedef logic [19:0] vec1_t;
  typedef logic [79:0] vec3_t;

  keccak_share_compress #(.d(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ap_in(in1[0]), .bp_in(in1[1]), .cp_in(in1[2]), .dp_in(in1[3]), .ep_in(in1[4]),
    .in_valid(iv1), .in_ready(ir1),
    .a_out(out1[0]), .b_out(out1[1]), .c_out(out1[2]), .d_out(out1[3]), .e_out(out1[4]),
    .out_valid(ov1), .out_ready(or1), .occupancy(occ1)
  );

  keccak_share_compress #(.d(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ap_in(in3[0]), .bp_in(in3[1]), .cp_in(in3[2]), .dp_in(in3[3]), .ep_in(in3[4]),
    .in_valid(iv3), .in_ready(ir3),
    .a_out(out3[0]), .b_out(out3[1]), .c_out(out3[2]), .d_out(out3[3]), .e_out(out3[4]),
    .out_valid(ov3), .out_ready(or3), .occupancy(occ3)
  );

  // Reference: compressed share i is the parity of expanded shares i*(d+1) .. i*(d+1)+d.
  function automatic logic [7:0] compress(input int dd, input logic [63:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i <= dd; i++)
      for (int j = 0; j <= dd; j++)
        r[i] = r[i] ^ x[i*(dd+1)+j];
    return r;
  endfunction

  function automatic logic [9:0] exp1(input vec1_t x);
    logic [9:0] r;
    logic [7:0] t;
    for (int b = 0; b < 5; b++) begin
      t = compress(1, 64'(x[b*4 +: 4]));
      r[b*2 +: 2] = t[1:0];
    end
    return r;
  endfunction

  function automatic logic [19:0] exp3(input vec3_t x);
    logic [19:0] r;
    logic [7:0]  t;
    for (int b = 0; b < 5; b++) begin
      t = compress(3, 64'(x[b*16 +: 16]));
      r[b*4 +: 4] = t[3:0];
    end
    return r;
  endfunction

  function automatic logic [9:0] got1();
    return {out1[4], out1[3], out1[2], out1[1], out1[0]};
  endfunction

  function automatic logic [19:0] got3();
    return {out3[4], out3[3], out3[2], out3[1], out3[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input vec1_t data);
    iv1 = v;
    for (int b = 0; b < 5; b++) in1[b] = data[b*4 +: 4];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    drive1(1'b0, '0); or1 = 1'b0;
    iv3 = 1'b0; or3 = 1'b0;
    for (int b = 0; b < 5; b++) in3[b] = '0;
    #12;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ov1); end
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occ1); end
    checks++; if (got1() !== 10'd0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", got1()); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL reset_out_valid_d3 got=%0b exp=0", ov3); end
    checks++; if (got3() !== 20'd0) begin failures++; $display("FAIL reset_outputs_d3 got=%0h exp=0", got3()); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    or1 = 1'b1;
    drive1(1'b1, 20'h00006);
    step();
    drive1(1'b0, '0);
    checks++; if (occ1 !== 2'd1) begin failures++; $display("FAIL single_occ_e got=%0d exp=1", occ1); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", ov1); end
    step();
    checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", ov1); end
    checks++; if (got1() !== 10'b00_00_00_00_11) begin failures++; $display("FAIL single_data got=%0h exp=3", got1()); end
    step();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin failures++; $display("FAIL single_drain got=%0b/%0d exp=0/0", ov1, occ1); end
    checks++; if (got1() !== 10'd0) begin failures++; $display("FAIL single_cleared got=%0h exp=0", got1()); end
  endtask

  task automatic test_back_to_back();
    vec1_t data [10];
    int first, last, n;
    first = -1; last = -1; n = 0;
    for (int k = 0; k < 10; k++) data[k] = 20'($urandom);
    or1 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 10) drive1(1'b1, data[k]); else drive1(1'b0, '0);
      #1;
      if (k < 10) begin
        checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", k, ir1); end
      end
      if (ov1 === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        checks++;
        if (n >= 10) begin failures++; $display("FAIL b2b_extra_output cyc=%0d got=%0h exp=none", k, got1()); end
        else if (got1() !== exp1(data[n])) begin failures++; $display("FAIL b2b_data idx=%0d got=%0h exp=%0h", n, got1(), exp1(data[n])); end
        n++;
      end
      step();
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", n); end
    checks++; if (first !== 2 || last !== 11) begin failures++; $display("FAIL b2b_timing got=%0d..%0d exp=2..11", first, last); end
  endtask

  task automatic test_stall();
    vec1_t a, b, c;
    a = 20'($urandom); b = 20'($urandom); c = 20'($urandom);
    or1 = 1'b0;
    drive1(1'b1, a); step();
    drive1(1'b1, b); step();
    drive1(1'b1, c);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL stall_occ cyc=%0d got=%0d exp=2", k, occ1); end
      checks++; if (ir1 !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", k, ir1); end
      checks++; if (ov1 !== 1'b1 || got1() !== exp1(a)) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0b/%0h exp=1/%0h", k, ov1, got1(), exp1(a)); end
      step();
    end
    drive1(1'b0, '0);
    or1 = 1'b1;
    #1;
    checks++; if (ov1 !== 1'b1 || got1() !== exp1(a)) begin failures++; $display("FAIL stall_first got=%0b/%0h exp=1/%0h", ov1, got1(), exp1(a)); end
    step();
    checks++; if (ov1 !== 1'b1 || got1() !== exp1(b)) begin failures++; $display("FAIL stall_second got=%0b/%0h exp=1/%0h", ov1, got1(), exp1(b)); end
    step();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin failures++; $display("FAIL stall_drain got=%0b/%0d exp=0/0", ov1, occ1); end
  endtask

  task automatic test_flush();
    or1 = 1'b0;
    drive1(1'b1, 20'($urandom)); step();
    drive1(1'b1, 20'($urandom)); step();
    checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occ1); end
    drive1(1'b1, 20'($urandom | 1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive1(1'b0, '0);
    #1;
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occ1); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", ov1); end
    checks++; if (got1() !== 10'd0) begin failures++; $display("FAIL flush_data got=%0h exp=0", got1()); end
    or1 = 1'b1;
    step(); step();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin failures++; $display("FAIL flush_ignored_input got=%0b/%0d exp=0/0", ov1, occ1); end
  endtask

  task automatic test_async_reset();
    vec1_t a, b, c;
    a = 20'($urandom | 1); b = 20'($urandom); c = 20'($urandom);
    or1 = 1'b1;
    drive1(1'b1, a); step();
    drive1(1'b0, '0); step();
    checks++; if (occ1 !== 2'd1 || ov1 !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0d/%0b exp=1/1", occ1, ov1); end
    or1 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", ov1); end
    checks++; if (got1() !== 10'd0) begin failures++; $display("FAIL areset_data got=%0h exp=0", got1()); end
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL areset_occ got=%0d exp=0", occ1); end
    #1;
    rst_n = 1'b1;
    or1 = 1'b1;
    step();
    drive1(1'b1, b); step();
    drive1(1'b1, c); step();
    drive1(1'b0, '0);
    checks++; if (ov1 !== 1'b1 || got1() !== exp1(b)) begin failures++; $display("FAIL areset_first got=%0b/%0h exp=1/%0h", ov1, got1(), exp1(b)); end
    step();
    checks++; if (ov1 !== 1'b1 || got1() !== exp1(c)) begin failures++; $display("FAIL areset_second got=%0b/%0h exp=1/%0h", ov1, got1(), exp1(c)); end
    step();
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL areset_drain got=%0b exp=0", ov1); end
  endtask

  task automatic test_random();
    vec3_t q [$];
    vec3_t x, cur;
    logic prev_stall;
    logic [19:0] prev_out;
    logic [4:0] par_in, par_out;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv3 = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 5; b++) cur[b*16 +: 16] = 16'($urandom);
      for (int b = 0; b < 5; b++) in3[b] = cur[b*16 +: 16];
      or3 = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (occ3 !== 2'(q.size())) begin failures++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, occ3, q.size()); end
      checks++; if (ir3 !== ((q.size() < 2) || or3)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, ir3, (q.size() < 2) || or3); end
      if (prev_stall) begin
        checks++; if (ov3 !== 1'b1 || got3() !== prev_out) begin failures++; $display("FAIL rnd_hold cyc=%0d got=%0b/%0h exp=1/%0h", cyc, ov3, got3(), prev_out); end
      end
      if (ov3 === 1'b1 && or3) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious cyc=%0d got=%0h exp=none", cyc, got3());
        end else begin
          x = q.pop_front();
          if (got3() !== exp3(x)) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, got3(), exp3(x)); end
          for (int b = 0; b < 5; b++) begin
            par_in[b]  = ^x[b*16 +: 16];
            par_out[b] = ^out3[b];
          end
          checks++; if (par_out !== par_in) begin failures++; $display("FAIL rnd_parity cyc=%0d got=%0h exp=%0h", cyc, par_out, par_in); end
        end
      end
      if (iv3 && ir3 === 1'b1) q.push_back(cur);
      prev_stall = (ov3 === 1'b1) && !or3;
      prev_out = got3();
      step();
    end
    iv3 = 1'b0;
    or3 = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      if (ov3 === 1'b1) begin
        x = q.pop_front();
        checks++; if (got3() !== exp3(x)) begin failures++; $display("FAIL rnd_drain got=%0h exp=%0h", got3(), exp3(x)); end
      end
      step();
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_drain_timeout got=%0d exp=0 pending", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
